// File: rtl/alm_mac_accum_if.sv
// Streaming bus between the approximate-log multiplier and the dot-product
// accumulator.
//   in_valid/in_ready/in_prod      : product stream into the accumulator
//   out_valid/out_ready/out_acc/out_sat : completed dot-product result
// The master modport is the producer/consumer side; the slave modport is the
// accumulator itself.
interface alm_mac_accum_if #(
  parameter int PROD_W = 17,
  parameter int ACC_W  = 24
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_prod;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_acc;
  logic                     out_sat;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_acc, out_sat
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_acc, out_sat
  );
endinterface

// File: rtl/alm_mac_accum.sv
// Saturating dot-product accumulator for approximate-log multiplier products.
// Sums LEN signed products into an ACC_W accumulator that clamps instead of
// wrapping, then presents the result with a sticky saturation flag.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous abort, discards partial sum and any pending result
//   bus   : slave side of alm_mac_accum_if (input product stream, result)
module alm_mac_accum #(
  parameter int PROD_W = 17,
  parameter int ACC_W  = 24,
  parameter int LEN    = 16
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clr,
  alm_mac_accum_if.slave  bus
);
  localparam int CW = $clog2(LEN + 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [CW-1:0]            cnt;
  logic                     sticky;
  logic                     rdy_q;
  logic                     vld_q;
  logic signed [ACC_W-1:0]  res_q;
  logic                     sat_q;

  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W-1:0]  sum_sat;
  logic                     ovf;
  logic                     in_xfer;
  logic                     out_xfer;

  // One guard bit is enough: ACC_W >= PROD_W+1 keeps the true sum inside
  // ACC_W+1 bits, so a guard/sign disagreement is exactly an overflow.
  always_comb begin
    sum      = {acc[ACC_W-1], acc} +
               {{(ACC_W+1-PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
    ovf      = sum[ACC_W] ^ sum[ACC_W-1];
    sum_sat  = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    in_xfer  = bus.in_valid & rdy_q;
    out_xfer = vld_q & bus.out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      res_q  <= '0;
      sat_q  <= 1'b0;
    end else if (clr) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          // rdy_q rises here on the first edge after reset release
          rdy_q <= 1'b1;
          if (in_xfer) begin
            if (cnt == LAST_CNT) begin
              res_q  <= sum_sat;
              sat_q  <= sticky | ovf;
              vld_q  <= 1'b1;
              rdy_q  <= 1'b0;
              state  <= DONE;
              acc    <= '0;
              cnt    <= '0;
              sticky <= 1'b0;
            end else begin
              acc    <= sum_sat;
              sticky <= sticky | ovf;
              cnt    <= cnt + 1'b1;
              state  <= ACCUM;
            end
          end
        end
        DONE: begin
          // in_ready stays low through the transfer cycle; the first new
          // product is taken on the following edge
          if (out_xfer) begin
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = vld_q;
  assign bus.out_acc   = res_q;
  assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_alm_mac_accum.sv
// Directed bench for alm_mac_accum: three instances cover LEN=4/ACC_W=24,
// LEN=4/ACC_W=18 (saturation) and LEN=1.
module tb_alm_mac_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_a = 1'b0, clr_s = 1'b0, clr_1 = 1'b0;
  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  alm_mac_accum_if #(.PROD_W(17), .ACC_W(24)) if_a ();
  alm_mac_accum_if #(.PROD_W(17), .ACC_W(18)) if_s ();
  alm_mac_accum_if #(.PROD_W(17), .ACC_W(24)) if_1 ();

  alm_mac_accum #(.PROD_W(17), .ACC_W(24), .LEN(4)) dut_a (.clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(if_a));
  alm_mac_accum #(.PROD_W(17), .ACC_W(18), .LEN(4)) dut_s (.clk(clk), .rst_n(rst_n), .clr(clr_s), .bus(if_s));
  alm_mac_accum #(.PROD_W(17), .ACC_W(24), .LEN(1)) dut_1 (.clk(clk), .rst_n(rst_n), .clr(clr_1), .bus(if_1));

  task automatic push_a(input logic signed [16:0] p);
    if_a.in_valid = 1'b1; if_a.in_prod = p;
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
  endtask

  task automatic push_s(input logic signed [16:0] p);
    if_s.in_valid = 1'b1; if_s.in_prod = p;
    @(posedge clk); #1;
    if_s.in_valid = 1'b0;
  endtask

  task automatic push_1(input logic signed [16:0] p);
    if_1.in_valid = 1'b1; if_1.in_prod = p;
    @(posedge clk); #1;
    if_1.in_valid = 1'b0;
  endtask

  task automatic take_a();
    if_a.out_ready = 1'b1;
    @(posedge clk); #1;
    if_a.out_ready = 1'b0;
  endtask

  task automatic take_s();
    if_s.out_ready = 1'b1;
    @(posedge clk); #1;
    if_s.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vec++; if (if_a.in_ready !== 1'b0) begin miss++; $display("FAIL rst_in_ready_a: got %b want 0", if_a.in_ready); end
    vec++; if (if_a.out_valid !== 1'b0) begin miss++; $display("FAIL rst_out_valid_a: got %b want 0", if_a.out_valid); end
    vec++; if (if_a.out_acc !== 24'sd0) begin miss++; $display("FAIL rst_out_acc_a: got %0d want 0", if_a.out_acc); end
    vec++; if (if_a.out_sat !== 1'b0) begin miss++; $display("FAIL rst_out_sat_a: got %b want 0", if_a.out_sat); end
    vec++; if (if_1.in_ready !== 1'b0) begin miss++; $display("FAIL rst_in_ready_1: got %b want 0", if_1.in_ready); end
    rst_n = 1'b1;
    vec++; if (if_a.in_ready !== 1'b0) begin miss++; $display("FAIL rel_in_ready_early: got %b want 0", if_a.in_ready); end
    @(posedge clk); #1;
    vec++; if (if_a.in_ready !== 1'b1) begin miss++; $display("FAIL rel_in_ready_a: got %b want 1", if_a.in_ready); end
    vec++; if (if_s.in_ready !== 1'b1) begin miss++; $display("FAIL rel_in_ready_s: got %b want 1", if_s.in_ready); end
    vec++; if (if_1.in_ready !== 1'b1) begin miss++; $display("FAIL rel_in_ready_1: got %b want 1", if_1.in_ready); end
  endtask

  task automatic test_basic();
    push_a(17'sd100); push_a(-17'sd50); push_a(17'sd200); push_a(17'sd7);
    vec++; if (if_a.out_valid !== 1'b1) begin miss++; $display("FAIL basic_valid: got %b want 1", if_a.out_valid); end
    vec++; if (if_a.out_acc !== 24'sd257) begin miss++; $display("FAIL basic_acc: got %0d want 257", if_a.out_acc); end
    vec++; if (if_a.out_sat !== 1'b0) begin miss++; $display("FAIL basic_sat: got %b want 0", if_a.out_sat); end
    vec++; if (if_a.in_ready !== 1'b0) begin miss++; $display("FAIL basic_done_rdy: got %b want 0", if_a.in_ready); end
    take_a();
    vec++; if (if_a.out_valid !== 1'b0) begin miss++; $display("FAIL basic_drain_valid: got %b want 0", if_a.out_valid); end
    vec++; if (if_a.in_ready !== 1'b1) begin miss++; $display("FAIL basic_drain_rdy: got %b want 1", if_a.in_ready); end
  endtask

  task automatic test_gaps();
    push_a(17'sd5); repeat (3) @(posedge clk); #1;
    push_a(-17'sd2); @(posedge clk); #1;
    push_a(17'sd10); push_a(-17'sd13);
    vec++; if (if_a.out_valid !== 1'b1) begin miss++; $display("FAIL gaps_valid: got %b want 1", if_a.out_valid); end
    vec++; if (if_a.out_acc !== 24'sd0) begin miss++; $display("FAIL gaps_acc: got %0d want 0", if_a.out_acc); end
    take_a();
  endtask

  task automatic test_saturation();
    logic signed [17:0] e_max, e_min;
    e_max = 18'h1FFFF; e_min = 18'h20000;
    repeat (4) push_s(17'sd60000);
    vec++; if (if_s.out_acc !== e_max) begin miss++; $display("FAIL sat_pos_acc: got %0d want %0d", if_s.out_acc, e_max); end
    vec++; if (if_s.out_sat !== 1'b1) begin miss++; $display("FAIL sat_pos_flag: got %b want 1", if_s.out_sat); end
    take_s();
    repeat (4) push_s(-17'sd60000);
    vec++; if (if_s.out_acc !== e_min) begin miss++; $display("FAIL sat_neg_acc: got %0d want %0d", if_s.out_acc, e_min); end
    vec++; if (if_s.out_sat !== 1'b1) begin miss++; $display("FAIL sat_neg_flag: got %b want 1", if_s.out_sat); end
    take_s();
    repeat (4) push_s(17'sd1);
    vec++; if (if_s.out_acc !== 18'sd4) begin miss++; $display("FAIL sat_clear_acc: got %0d want 4", if_s.out_acc); end
    vec++; if (if_s.out_sat !== 1'b0) begin miss++; $display("FAIL sat_clear_flag: got %b want 0", if_s.out_sat); end
    take_s();
  endtask

  task automatic test_backpressure();
    push_a(17'sd1); push_a(17'sd2); push_a(17'sd3); push_a(17'sd4);
    if_a.in_valid = 1'b1; if_a.in_prod = 17'sd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vec++; if (if_a.out_valid !== 1'b1) begin miss++; $display("FAIL bp_valid[%0d]: got %b want 1", i, if_a.out_valid); end
      vec++; if (if_a.out_acc !== 24'sd10) begin miss++; $display("FAIL bp_acc[%0d]: got %0d want 10", i, if_a.out_acc); end
      vec++; if (if_a.in_ready !== 1'b0) begin miss++; $display("FAIL bp_rdy[%0d]: got %b want 0", i, if_a.in_ready); end
    end
    if_a.out_ready = 1'b1;
    @(posedge clk); #1;
    if_a.out_ready = 1'b0; if_a.in_valid = 1'b0;
    vec++; if (if_a.out_valid !== 1'b0) begin miss++; $display("FAIL bp_accept: got %b want 0", if_a.out_valid); end
    vec++; if (if_a.in_ready !== 1'b1) begin miss++; $display("FAIL bp_rdy_after: got %b want 1", if_a.in_ready); end
    repeat (4) push_a(17'sd1);
    vec++; if (if_a.out_acc !== 24'sd4) begin miss++; $display("FAIL bp_no_leak: got %0d want 4", if_a.out_acc); end
    take_a();
  endtask

  task automatic test_clr();
    push_a(17'sd1000); push_a(17'sd1000);
    clr_a = 1'b1; if_a.in_valid = 1'b1; if_a.in_prod = 17'sd5;
    @(posedge clk); #1;
    clr_a = 1'b0; if_a.in_valid = 1'b0;
    vec++; if (if_a.in_ready !== 1'b1) begin miss++; $display("FAIL clr_rdy: got %b want 1", if_a.in_ready); end
    push_a(17'sd1); push_a(17'sd2); push_a(17'sd3); push_a(17'sd4);
    vec++; if (if_a.out_acc !== 24'sd10) begin miss++; $display("FAIL clr_acc: got %0d want 10", if_a.out_acc); end
    vec++; if (if_a.out_sat !== 1'b0) begin miss++; $display("FAIL clr_sat: got %b want 0", if_a.out_sat); end
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    vec++; if (if_a.out_valid !== 1'b0) begin miss++; $display("FAIL clr_done_valid: got %b want 0", if_a.out_valid); end
    vec++; if (if_a.in_ready !== 1'b1) begin miss++; $display("FAIL clr_done_rdy: got %b want 1", if_a.in_ready); end
  endtask

  task automatic test_reset_mid();
    push_a(17'sd1000); push_a(17'sd1000);
    rst_n = 1'b0;
    #1;
    vec++; if (if_a.in_ready !== 1'b0) begin miss++; $display("FAIL rmid_rdy: got %b want 0", if_a.in_ready); end
    vec++; if (if_a.out_acc !== 24'sd0) begin miss++; $display("FAIL rmid_acc: got %0d want 0", if_a.out_acc); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec++; if (if_a.in_ready !== 1'b1) begin miss++; $display("FAIL rmid_rel_rdy: got %b want 1", if_a.in_ready); end
    repeat (4) push_a(17'sd1);
    vec++; if (if_a.out_acc !== 24'sd4) begin miss++; $display("FAIL rmid_acc4: got %0d want 4", if_a.out_acc); end
    take_a();
  endtask

  task automatic test_len1();
    if_1.out_ready = 1'b1;
    push_1(-17'sd3);
    vec++; if (if_1.out_valid !== 1'b1) begin miss++; $display("FAIL len1_v0: got %b want 1", if_1.out_valid); end
    vec++; if (if_1.out_acc !== -24'sd3) begin miss++; $display("FAIL len1_acc0: got %0d want -3", if_1.out_acc); end
    vec++; if (if_1.in_ready !== 1'b0) begin miss++; $display("FAIL len1_rdy0: got %b want 0", if_1.in_ready); end
    @(posedge clk); #1;
    vec++; if (if_1.in_ready !== 1'b1) begin miss++; $display("FAIL len1_rdy_mid: got %b want 1", if_1.in_ready); end
    push_1(17'sd9);
    vec++; if (if_1.out_acc !== 24'sd9) begin miss++; $display("FAIL len1_acc1: got %0d want 9", if_1.out_acc); end
    vec++; if (if_1.in_ready !== 1'b0) begin miss++; $display("FAIL len1_rdy1: got %b want 0", if_1.in_ready); end
    @(posedge clk); #1;
    vec++; if (if_1.out_valid !== 1'b0) begin miss++; $display("FAIL len1_drain: got %b want 0", if_1.out_valid); end
    if_1.out_ready = 1'b0;
  endtask

  initial begin
    if_a.in_valid = 1'b0; if_a.in_prod = '0; if_a.out_ready = 1'b0;
    if_s.in_valid = 1'b0; if_s.in_prod = '0; if_s.out_ready = 1'b0;
    if_1.in_valid = 1'b0; if_1.in_prod = '0; if_1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_backpressure();
    test_clr();
    test_reset_mid();
    test_len1();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alm_mac_accum.md
ALM_MAC_ACCUM -- requirements
Module: alm_mac_accum

Interface
REQ-001 SHALL have parameter PROD_W, default 17, width of the signed product from the approximate log multiplier.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator and result width; legal range ACC_W >= PROD_W+1.
REQ-003 SHALL have parameter LEN, default 16, products per dot-product result; legal range 1..65535.
REQ-004 SHALL have one clock and an asynchronous active-low reset; all other ports are synchronous to clk.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  synchronous abort: discard partial sum and pending result.
REQ-008 in_valid  input  1  in_prod is valid this cycle.
REQ-009 in_ready  output  1  block accepts in_prod this cycle.
REQ-010 in_prod  input  PROD_W  two's-complement product (multiplier output p).
REQ-011 out_valid  output  1  out_acc and out_sat hold a completed result.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out_acc  output  ACC_W  two's-complement saturated dot product.
REQ-014 out_sat  output  1  saturation occurred at least once in this result.

Function
REQ-015 SHALL transfer an input when in_valid and in_ready are both high at a rising edge; likewise an output when out_valid and out_ready are both high.
REQ-016 SHALL implement states IDLE (count=0, acc=0), ACCUM (1 <= count <= LEN-1), DONE (out_valid=1).
REQ-017 SHALL drive in_ready = 1 in IDLE and ACCUM, 0 in DONE, purely from registered state.
REQ-018 On each accepted input SHALL compute sum = acc + sign-extended in_prod at ACC_W+1 bits.
REQ-019 SHALL clamp sum to 2^(ACC_W-1)-1 on positive overflow and -2^(ACC_W-1) on negative overflow, and set a sticky sat flag.
REQ-020 SHALL continue accumulating from the clamped value after saturation; no wrap-around is ever visible.
REQ-021 On the LEN-th accepted input SHALL load out_acc with the clamped sum, load out_sat with the sticky flag including this step, assert out_valid next cycle, enter DONE, and clear acc, count and sticky flag.
REQ-022 Latency SHALL be one cycle from the LEN-th input transfer to out_valid high.
REQ-023 IDLE -> ACCUM on accepted input when LEN>1; IDLE/ACCUM -> DONE on LEN-th accepted input; DONE -> IDLE on output transfer.
REQ-024 With LEN=1 every accepted input SHALL go directly to DONE.
REQ-025 In DONE out_acc, out_sat and out_valid SHALL stay stable until the output transfer, regardless of in_valid.
REQ-026 The output transfer cycle SHALL NOT accept an input (in_ready low); first new input is accepted the cycle after.
REQ-027 count SHALL be ceil(log2(LEN+1)) bits and SHALL never exceed LEN-1 outside DONE.
REQ-028 clr SHALL take priority over all transfers: next state IDLE, acc=0, count=0, sticky flag=0, out_valid=0; in_prod presented with clr SHALL be discarded.
REQ-029 in_valid low SHALL hold all state; gaps between inputs SHALL NOT affect the result.

Reset
REQ-030 While rst_n is low SHALL hold state IDLE, acc=0, count=0, sticky flag=0, out_valid=0, out_acc=0, out_sat=0, in_ready=0.
REQ-031 in_ready SHALL rise on the first clk edge after rst_n deasserts; reset mid-accumulation SHALL discard the partial sum.

Verification
REQ-032 LEN=4, ACC_W=24: inputs 100, -50, 200, 7 back-to-back -> one cycle later out_valid=1, out_acc=257, out_sat=0.
REQ-033 LEN=4, ACC_W=18: four inputs of 60000 -> out_acc=131071, out_sat=1; four inputs of -60000 -> out_acc=-131072, out_sat=1.
REQ-034 LEN=4: out_ready held low 5 cycles after out_valid -> out_acc stable, in_ready=0 throughout, result accepted on the first out_ready cycle, in_ready=1 the next.
REQ-035 LEN=4: two inputs of 1000, then clr with in_valid=1 and in_prod=5, then 1, 2, 3, 4 -> out_acc=10, out_sat=0.
REQ-036 LEN=4: rst_n pulsed low after two inputs -> outputs zero, in_ready=1 on the first edge after release, next four inputs 1, 1, 1, 1 -> out_acc=4.
REQ-037 LEN=1: inputs -3 then 9 with out_ready=1 -> results -3 then 9, in_ready low in each DONE cycle.
